lab3_cache_mem_responder: RTL and testbench

Memory-side responder for the cache's refill/evict traffic. It accepts 4B word requests (`mem_req_4B_t`) issued by the cache's batch-send path and services them from an internal word-addressed array. After a fixed, parameterized latency it returns `mem_resp_4B_t` responses to the cache's batch-receive path. It sits between the cache controller's memory interface and the test harness, and it can also be preloaded through a side port.

---
 rtl/lab3_cache_pkg.sv | 30 +++
 rtl/lab3_cache_latency_counter.sv | 40 ++++
 rtl/lab3_cache_mem_responder.sv | 145 ++++++++++++++
 tb/tb_lab3_cache_mem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_cache_pkg.sv
// Shared types and constants for the lab3 cache memory-side blocks.
// The message layouts mirror the existing 4-byte memory-message header.
package lab3_cache_pkg;

  localparam logic [2:0] c_mem_read  = 3'd0;
  localparam logic [2:0] c_mem_write = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_t;

endpackage

// File: rtl/lab3_cache_latency_counter.sv
// Loadable down-counter used to time the responder's response latency.
// done flags the last wait cycle (count==1), or a zero-latency load.
module lab3_cache_latency_counter #(
  parameter int p_width = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [p_width-1:0] load_val,
  input  logic               en,
  output logic               done
);

  logic [p_width-1:0] count_q;
  logic [p_width-1:0] count_d;

  // Next count: load wins over decrement; saturate at zero.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = load ? (load_val == '0) : (count_q == p_width'(1));

endmodule

// File: rtl/lab3_cache_mem_responder.sv
// Memory-side responder for cache refill/evict traffic: services 4B word
// requests from an internal word array and answers after p_latency cycles.
// A side port preloads the array in any state.
module lab3_cache_mem_responder
  import lab3_cache_pkg::*;
#(
  parameter int p_num_words = 256,
  parameter int p_latency   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  mem_req_4B_t  memreq_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output mem_resp_4B_t memresp_msg,
  input  logic         init_en,
  input  logic [31:0]  init_addr,
  input  logic [31:0]  init_data
);

  localparam int c_idx_w = $clog2(p_num_words);
  localparam int c_cnt_w = $clog2(p_latency + 1);

  resp_state_t  state_q, state_d;
  logic [2:0]   type_q, type_d;
  logic [7:0]   opaque_q, opaque_d;
  logic [1:0]   len_q, len_d;
  logic [31:0]  data_q, data_d;

  logic [31:0]  mem_q [p_num_words];

  logic [c_idx_w-1:0] req_idx;
  logic [c_idx_w-1:0] init_idx;
  logic               mem_wr_en;
  logic               cnt_load;
  logic               cnt_en;
  logic               cnt_done;
  logic               accept;

  // Addresses wrap on the array depth; byte offset and upper bits do not matter.
  assign req_idx  = memreq_msg.addr[c_idx_w+1:2];
  assign init_idx = init_addr[c_idx_w+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{memreq_msg.addr[31:c_idx_w+2], memreq_msg.addr[1:0],
                              init_addr[31:c_idx_w+2], init_addr[1:0]};

  lab3_cache_latency_counter #(
    .p_width (c_cnt_w)
  ) u_latency_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (c_cnt_w'(p_latency - 1)),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  // Next-state, handshake outputs and request capture for the responder FSM.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    opaque_d    = opaque_q;
    len_d       = len_q;
    data_d      = data_q;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    mem_wr_en   = 1'b0;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;

    case (state_q)
      ST_IDLE: memreq_rdy = 1'b1;
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (cnt_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        memresp_val = 1'b1;
        memreq_rdy  = memresp_rdy;
        if (memresp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (reset) begin
      memreq_rdy  = 1'b0;
      memresp_val = 1'b0;
    end

    accept = memreq_val && memreq_rdy;
    if (accept) begin
      type_d   = memreq_msg.type_;
      opaque_d = memreq_msg.opaque;
      len_d    = memreq_msg.len;
      cnt_load = 1'b1;
      state_d  = (p_latency > 1) ? ST_WAIT : ST_RESP;
      if (memreq_msg.type_ == c_mem_write) begin
        mem_wr_en = 1'b1;
        data_d    = '0;
      end else begin
        data_d = mem_q[req_idx];
      end
    end

    if (reset) begin
      state_d  = ST_IDLE;
      type_d   = '0;
      opaque_d = '0;
      len_d    = '0;
      data_d   = '0;
    end
  end

  // Response message is forced to zero while reset is held.
  always_comb begin
    memresp_msg = '0;
    if (!reset) begin
      memresp_msg.type_  = type_q;
      memresp_msg.opaque = opaque_q;
      memresp_msg.test   = 2'b0;
      memresp_msg.len    = len_q;
      memresp_msg.data   = data_q;
    end
  end

  // FSM state and latched response fields.
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    type_q   <= type_d;
    opaque_q <= opaque_d;
    len_q    <= len_d;
    data_q   <= data_d;
  end

  // Word array writes; a request write to the same word overrides the preload.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset, so preloaded and committed data survive reset.
    if (init_en)   mem_q[init_idx] <= init_data;
    if (mem_wr_en) mem_q[req_idx]  <= memreq_msg.data;
  end

endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// Directed bench for the memory responder: one latency-2 instance and one
// latency-1 instance driven by a single linear stimulus sequence.
module tb_lab3_cache_mem_responder;
  import lab3_cache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Instance A: p_latency = 2
  logic         a_reset, a_req_val, a_req_rdy, a_resp_val, a_resp_rdy, a_init_en;
  mem_req_4B_t  a_req_msg;
  mem_resp_4B_t a_resp_msg;
  logic [31:0]  a_init_addr, a_init_data;

  // Instance B: p_latency = 1
  logic         b_reset, b_req_val, b_req_rdy, b_resp_val, b_resp_rdy, b_init_en;
  mem_req_4B_t  b_req_msg;
  mem_resp_4B_t b_resp_msg;
  logic [31:0]  b_init_addr, b_init_data;

  lab3_cache_mem_responder #(.p_num_words(256), .p_latency(2)) dut_a (
    .clk         (clk),
    .reset       (a_reset),
    .memreq_val  (a_req_val),
    .memreq_rdy  (a_req_rdy),
    .memreq_msg  (a_req_msg),
    .memresp_val (a_resp_val),
    .memresp_rdy (a_resp_rdy),
    .memresp_msg (a_resp_msg),
    .init_en     (a_init_en),
    .init_addr   (a_init_addr),
    .init_data   (a_init_data)
  );

  lab3_cache_mem_responder #(.p_num_words(256), .p_latency(1)) dut_b (
    .clk         (clk),
    .reset       (b_reset),
    .memreq_val  (b_req_val),
    .memreq_rdy  (b_req_rdy),
    .memreq_msg  (b_req_msg),
    .memresp_val (b_resp_val),
    .memresp_rdy (b_resp_rdy),
    .memresp_msg (b_resp_msg),
    .init_en     (b_init_en),
    .init_addr   (b_init_addr),
    .init_data   (b_init_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic mem_req_4B_t req(input logic [2:0] t, input logic [7:0] op,
                                      input logic [31:0] addr, input logic [1:0] len,
                                      input logic [31:0] data);
    mem_req_4B_t m;
    m.type_  = t;
    m.opaque = op;
    m.addr   = addr;
    m.len    = len;
    m.data   = data;
    return m;
  endfunction

  function automatic mem_resp_4B_t rsp(input logic [2:0] t, input logic [7:0] op,
                                       input logic [1:0] len, input logic [31:0] data);
    mem_resp_4B_t m;
    m.type_  = t;
    m.opaque = op;
    m.test   = 2'b0;
    m.len    = len;
    m.data   = data;
    return m;
  endfunction

  task automatic chk_a_hs(input string tag, input logic rdy, input logic val);
    check({tag, "_rdy"}, {63'b0, a_req_rdy}, {63'b0, rdy});
    check({tag, "_val"}, {63'b0, a_resp_val}, {63'b0, val});
  endtask

  task automatic chk_a_msg(input string tag, input mem_resp_4B_t exp);
    check({tag, "_msg"}, {17'b0, a_resp_msg}, {17'b0, exp});
  endtask

  task automatic drive_a(input logic v, input mem_req_4B_t m);
    a_req_val = v;
    a_req_msg = m;
  endtask

  task automatic init_a(input logic en, input logic [31:0] addr, input logic [31:0] data);
    a_init_en   = en;
    a_init_addr = addr;
    a_init_data = data;
  endtask

  initial begin
    a_reset = 1'b1; a_req_val = 1'b0; a_req_msg = '0; a_resp_rdy = 1'b0;
    a_init_en = 1'b0; a_init_addr = '0; a_init_data = '0;
    b_reset = 1'b1; b_req_val = 1'b0; b_req_msg = '0; b_resp_rdy = 1'b0;
    b_init_en = 1'b0; b_init_addr = '0; b_init_data = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk_a_hs("reset", 1'b0, 1'b0);
    chk_a_msg("reset", '0);

    // First cycle out of reset: ready; preload 0x100
    @(negedge clk); a_reset = 1'b0; init_a(1'b1, 32'h100, 32'hDEADBEEF); #1;
    chk_a_hs("post_reset", 1'b1, 1'b0);

    // Read 0x100, opaque 0x5A
    @(negedge clk); init_a(1'b0, '0, '0); a_resp_rdy = 1'b1;
    drive_a(1'b1, req(c_mem_read, 8'h5A, 32'h100, 2'd0, 32'h0)); #1;
    chk_a_hs("rd100_accept", 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b0, '0); #1;
    chk_a_hs("rd100_wait", 1'b0, 1'b0);
    @(negedge clk); #1;
    chk_a_hs("rd100_resp", 1'b1, 1'b1);
    chk_a_msg("rd100_resp", rsp(c_mem_read, 8'h5A, 2'd0, 32'hDEADBEEF));

    // Write 0x44 to 0x200, then back-to-back read of 0x200
    @(negedge clk); drive_a(1'b1, req(c_mem_write, 8'h01, 32'h200, 2'd0, 32'h44)); #1;
    chk_a_hs("wr200_accept", 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b1, req(c_mem_read, 8'h02, 32'h200, 2'd2, 32'h0)); #1;
    chk_a_hs("wr200_wait", 1'b0, 1'b0);
    @(negedge clk); #1;
    chk_a_hs("wr200_resp", 1'b1, 1'b1);
    chk_a_msg("wr200_resp", rsp(c_mem_write, 8'h01, 2'd0, 32'h0));
    @(negedge clk); drive_a(1'b0, '0); a_resp_rdy = 1'b0; #1;
    chk_a_hs("rd200_wait", 1'b0, 1'b0);

    // Response stalled 5 cycles; a pending write must not be accepted
    @(negedge clk); drive_a(1'b1, req(c_mem_write, 8'h03, 32'h300, 2'd0, 32'h12345678)); #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk_a_hs("stall", 1'b0, 1'b1);
      chk_a_msg("stall", rsp(c_mem_read, 8'h02, 2'd2, 32'h44));
    end
    @(negedge clk); a_resp_rdy = 1'b1; #1;
    chk_a_hs("stall_release", 1'b1, 1'b1);
    chk_a_msg("stall_release", rsp(c_mem_read, 8'h02, 2'd2, 32'h44));
    @(negedge clk); drive_a(1'b0, '0); #1;
    chk_a_hs("wr300_wait", 1'b0, 1'b0);
    @(negedge clk); #1;
    chk_a_msg("wr300_resp", rsp(c_mem_write, 8'h03, 2'd0, 32'h0));

    // Wrap-around: write 0x404, read 0x004
    @(negedge clk); drive_a(1'b1, req(c_mem_write, 8'h04, 32'h404, 2'd0, 32'hAAAA5555)); #1;
    chk_a_hs("wr404_accept", 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b1, req(c_mem_read, 8'h05, 32'h004, 2'd0, 32'h0)); #1;
    @(negedge clk); #1;
    chk_a_msg("wr404_resp", rsp(c_mem_write, 8'h04, 2'd0, 32'h0));
    @(negedge clk); drive_a(1'b0, '0); #1;
    @(negedge clk); #1;
    chk_a_hs("rd004_resp", 1'b1, 1'b1);
    chk_a_msg("rd004_resp", rsp(c_mem_read, 8'h05, 2'd0, 32'hAAAA5555));

    // Write 0x300 then reset during WAIT: response dropped, write kept
    @(negedge clk); drive_a(1'b1, req(c_mem_write, 8'h06, 32'h300, 2'd0, 32'hCAFEF00D)); #1;
    chk_a_hs("wr300b_accept", 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b0, '0); a_reset = 1'b1; #1;
    chk_a_hs("mid_reset", 1'b0, 1'b0);
    chk_a_msg("mid_reset", '0);
    @(negedge clk); a_reset = 1'b0;
    drive_a(1'b1, req(c_mem_read, 8'h07, 32'h300, 2'd0, 32'h0)); #1;
    chk_a_hs("after_reset", 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b0, '0); #1;
    chk_a_hs("rd300_wait", 1'b0, 1'b0);
    @(negedge clk); #1;
    chk_a_msg("rd300_resp", rsp(c_mem_read, 8'h07, 2'd0, 32'hCAFEF00D));

    // Init/request collisions on 0x500
    @(negedge clk); drive_a(1'b1, req(c_mem_write, 8'h08, 32'h500, 2'd0, 32'h22222222));
    init_a(1'b1, 32'h500, 32'h11111111); #1;
    chk_a_hs("coll_wr_accept", 1'b1, 1'b0);
    @(negedge clk); drive_a(1'b0, '0); init_a(1'b0, '0, '0); #1;
    @(negedge clk); drive_a(1'b1, req(c_mem_read, 8'h09, 32'h500, 2'd0, 32'h0));
    init_a(1'b1, 32'h500, 32'h33333333); #1;
    chk_a_msg("coll_wr_resp", rsp(c_mem_write, 8'h08, 2'd0, 32'h0));
    @(negedge clk); drive_a(1'b0, '0); init_a(1'b0, '0, '0); #1;
    @(negedge clk); #1;
    chk_a_msg("coll_rd_old", rsp(c_mem_read, 8'h09, 2'd0, 32'h22222222));
    @(negedge clk); drive_a(1'b1, req(c_mem_read, 8'h0A, 32'h500, 2'd0, 32'h0)); #1;
    @(negedge clk); drive_a(1'b0, '0); #1;
    @(negedge clk); #1;
    chk_a_msg("coll_rd_new", rsp(c_mem_read, 8'h0A, 2'd0, 32'h33333333));

    // Instance B (latency 1): preload words 0..3, then stream 4 reads
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_reset = 1'b0; b_resp_rdy = 1'b1;
      b_init_en = 1'b1; b_init_addr = 32'(4 * i); b_init_data = 32'h1000 + 32'(i);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b_init_en = 1'b0;
      b_req_val = (k < 4);
      b_req_msg = req(c_mem_read, 8'(k), 32'(4 * k), 2'd0, 32'h0);
      #1;
      if (k == 0) begin
        check("stream_first_val", {63'b0, b_resp_val}, 64'd0);
      end else begin
        check($sformatf("stream%0d_val", k - 1), {63'b0, b_resp_val}, 64'd1);
        check($sformatf("stream%0d_msg", k - 1), {17'b0, b_resp_msg},
              {17'b0, rsp(c_mem_read, 8'(k - 1), 2'd0, 32'h1000 + 32'(k - 1))});
      end
      if (k < 4) check($sformatf("stream%0d_rdy", k), {63'b0, b_req_rdy}, 64'd1);
    end
    @(negedge clk); #1;
    check("stream_end_val", {63'b0, b_resp_val}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
